pipelined_adder: RTL and testbench
==================================

Name: pipelined_adder

Overview:
- Parametrised, segmented ripple adder/subtractor. Generalises the 4-bit full-adder chain to WIDTH bits.
- The carry chain is cut into WIDTH/SEG_WIDTH register stages. Operands enter through a valid/ready handshake.
- Results leave through a second valid/ready handshake, with carry-out and signed overflow.
- Sits between operand sources and accumulators in the datapath; sustains one operation per clock when not back-pressured.

Parameters:
- WIDTH, 16, operand/result width in bits; must be an integer multiple of SEG_WIDTH.
- SEG_WIDTH, 4, bits resolved per pipeline stage. STAGES = WIDTH/SEG_WIDTH (derived, not overridable).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand set present
- in_ready  output  1  block accepts operands this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- c_in  input  1  carry-in (add) / borrow-in (sub)
- sub  input  1  0 = add, 1 = subtract
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result this cycle
- sum  output  WIDTH  result
- c_out  output  1  carry out of MSB of raw addition
- ovf  output  1  signed two's-complement overflow

Behaviour:
- Reset: synchronous, active-high. On a clk edge with rst=1, all stage valid bits clear and sum, c_out, ovf are set to 0.
  - out_valid=0 from the cycle after reset.
  - in_ready follows its equation (=1 after reset).
  - In-flight operations are discarded; reset mid-operation is legal.
- Operation:
  - sub=0: {c_out,sum} = a + b + c_in.
  - sub=1: {c_out,sum} = a + ~b + ~c_in, i.e. a - b - c_in. c_out=1 means no borrow.
  - ovf = (A_msb == B'_msb) && (sum_msb != A_msb), where B' is b or ~b per sub.
- Pipeline:
  - Stage k (0..STAGES-1) adds bit segment k of a and B' with the carry from stage k-1. Stage 0 uses the effective carry-in.
  - Unresolved upper segments of A and B' are carried forward in skew registers.
  - Resolved lower segments are carried forward in de-skew registers, so every output bit appears in the same cycle.
- Latency: exactly STAGES cycles from accept (in_valid && in_ready at edge N) to out_valid at edge N+STAGES, given no stall.
- Stall:
  - adv = !out_valid || out_ready.
  - in_ready = adv.
  - When adv=0, every stage register, including valid bits, holds.
  - When adv=1, all stages shift by one. A bubble is inserted when in_valid=0.
- Output stability: while out_valid=1 and out_ready=0, sum/c_out/ovf are held unchanged.
- Throughput: one result per cycle with in_valid=out_ready=1 continuously. No bubbles are introduced by the block.
- Simultaneous events:
  - A new accept and an output handshake in the same cycle are both honoured.
  - rst overrides any handshake in that cycle.
- STAGES=1 is legal: single register stage, latency 1.
- WIDTH not divisible by SEG_WIDTH is an elaboration-time error.
- Wrap-around: the result is modulo 2^WIDTH. The carry is reported only on c_out, never truncated silently into sum.
- Inputs are sampled only on accept. a, b, c_in and sub are don't-care when in_valid=0.

Test Plan:
1. Reset, then single add (WIDTH=16, SEG_WIDTH=4): a=16'h1234, b=16'h4321, c_in=0, sub=0, out_ready=1 -> out_valid exactly 4 cycles after accept; sum=16'h5555, c_out=0, ovf=0.
2. Full cross-segment carry propagation: a=16'hFFFF, b=16'h0000, c_in=1 -> sum=16'h0000, c_out=1, ovf=0. Then a=16'h7FFF, b=16'h0001, c_in=0 -> sum=16'h8000, c_out=0, ovf=1.
3. Subtract with borrow: a=16'h0005, b=16'h0007, c_in=0, sub=1 -> sum=16'hFFFE, c_out=0. Then a=16'h8000, b=16'h0001, c_in=1, sub=1 -> sum=16'h7FFE, c_out=1, ovf=1.
4. Back-to-back streaming: accept 10 random operand sets on consecutive cycles with out_ready=1 -> 10 consecutive out_valid cycles, in order, each matching the reference model.
5. Back-pressure: stream 6 ops and drop out_ready for 3 cycles mid-stream.
   - in_ready=0 the cycle after the head result stalls.
   - The head result is held stable across the stall.
   - No result is lost or duplicated; order is preserved.
6. Reset mid-flight: accept 3 ops, assert rst for 1 cycle after 2 cycles -> out_valid stays 0 and no stale result emerges. A fresh op accepted after reset returns its correct result after 4 cycles.

Source files
------------

// File: rtl/pipelined_adder_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_adder_if
//  Description : Operand and result handshake bundle for pipelined_adder.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipelined_adder_if #(
    parameter int WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;

    // Master produces operands and consumes results.
    modport master (
        output in_valid, a, b, c_in, sub, out_ready,
        input  in_ready, out_valid, sum, c_out, ovf
    );

    modport slave (
        input  in_valid, a, b, c_in, sub, out_ready,
        output in_ready, out_valid, sum, c_out, ovf
    );
endinterface
`default_nettype wire

// File: rtl/pipelined_adder.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_adder
//  Description : Segmented ripple adder/subtractor; one carry segment per stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipelined_adder #(
    parameter int WIDTH     = 16,
    parameter int SEG_WIDTH = 4
) (
    input  wire logic           clk,
    input  wire logic           rst,
    pipelined_adder_if.slave    bus
);
    localparam int STAGES = WIDTH / SEG_WIDTH;

    if ((SEG_WIDTH < 1) || ((WIDTH % SEG_WIDTH) != 0)) begin : g_width_check
        $error("pipelined_adder: WIDTH must be a positive multiple of SEG_WIDTH");
    end

    logic adv;
    logic out_valid;

    // The whole pipe moves as one; a stalled head freezes every stage.
    assign adv          = !out_valid || bus.out_ready;
    assign bus.in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO  = k * SEG_WIDTH;
        localparam int HI  = LO + SEG_WIDTH;
        localparam int REM = WIDTH - LO;

        // a_src/bp_src hold only the segments not yet resolved at this stage.
        logic [REM-1:0]       a_src;
        logic [REM-1:0]       bp_src;
        logic                 cin_src;
        logic                 valid_src;
        logic [SEG_WIDTH:0]   seg_res;

        logic [HI-1:0]        sum_d;
        logic [HI-1:0]        sum_q;
        logic                 carry_d;
        logic                 carry_q;
        logic                 valid_d;
        logic                 valid_q;

        if (k == 0) begin : g_head
            assign a_src     = bus.a;
            assign bp_src    = bus.b ^ {WIDTH{bus.sub}};
            assign cin_src   = bus.c_in ^ bus.sub;
            assign valid_src = bus.in_valid;

            always_comb begin
                sum_d = seg_res[SEG_WIDTH-1:0];
            end
        end else begin : g_body
            assign a_src     = g_stage[k-1].g_skew.a_q;
            assign bp_src    = g_stage[k-1].g_skew.bp_q;
            assign cin_src   = g_stage[k-1].carry_q;
            assign valid_src = g_stage[k-1].valid_q;

            always_comb begin
                sum_d = {seg_res[SEG_WIDTH-1:0], g_stage[k-1].sum_q};
            end
        end

        always_comb begin
            seg_res = {1'b0, a_src[SEG_WIDTH-1:0]}
                    + {1'b0, bp_src[SEG_WIDTH-1:0]}
                    + {{SEG_WIDTH{1'b0}}, cin_src};
            carry_d = seg_res[SEG_WIDTH];
            valid_d = valid_src;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                sum_q   <= '0;
            end else if (adv) begin
                valid_q <= valid_d;
                carry_q <= carry_d;
                sum_q   <= sum_d;
            end
        end

        if (k < STAGES - 1) begin : g_skew
            logic [REM-SEG_WIDTH-1:0] a_d;
            logic [REM-SEG_WIDTH-1:0] a_q;
            logic [REM-SEG_WIDTH-1:0] bp_d;
            logic [REM-SEG_WIDTH-1:0] bp_q;

            always_comb begin
                a_d  = a_src[REM-1:SEG_WIDTH];
                bp_d = bp_src[REM-1:SEG_WIDTH];
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q  <= '0;
                    bp_q <= '0;
                end else if (adv) begin
                    a_q  <= a_d;
                    bp_q <= bp_d;
                end
            end
        end else begin : g_tail
            logic ovf_d;
            logic ovf_q;

            // Only the top segment is left here, so its MSB is the word MSB.
            always_comb begin
                ovf_d = (a_src[SEG_WIDTH-1] == bp_src[SEG_WIDTH-1])
                     && (seg_res[SEG_WIDTH-1] != a_src[SEG_WIDTH-1]);
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (adv) begin
                    ovf_q <= ovf_d;
                end
            end
        end
    end

    assign out_valid     = g_stage[STAGES-1].valid_q;
    assign bus.out_valid = out_valid;
    assign bus.sum       = g_stage[STAGES-1].sum_q;
    assign bus.c_out     = g_stage[STAGES-1].carry_q;
    assign bus.ovf       = g_stage[STAGES-1].g_tail.ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipelined_adder
//  Description : Scoreboard bench for pipelined_adder (WIDTH=16, SEG_WIDTH=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_adder;
    localparam int WIDTH     = 16;
    localparam int SEG_WIDTH = 4;
    localparam int STAGES    = WIDTH / SEG_WIDTH;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             c_out;
        logic             ovf;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    res_t exp_q[$];

    pipelined_adder_if #(.WIDTH(WIDTH)) bus ();

    pipelined_adder #(
        .WIDTH     (WIDTH),
        .SEG_WIDTH (SEG_WIDTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Independent reference: unsigned difference for the borrow, signed range for overflow.
    function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic cin, input logic sub);
        res_t         r;
        logic [WIDTH:0] u;
        int           s;
        if (sub) begin
            u       = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
            s       = int'($signed(a)) - int'($signed(b)) - int'(cin);
            r.c_out = ~u[WIDTH];
        end else begin
            u       = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
            s       = int'($signed(a)) + int'($signed(b)) + int'(cin);
            r.c_out = u[WIDTH];
        end
        r.sum = u[WIDTH-1:0];
        r.ovf = (s > 32767) || (s < -32768);
        return r;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.a         = 16'hFFFF;
        bus.b         = 16'h0001;
        bus.c_in      = 1'b1;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid got %b expected 0", bus.out_valid);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b expected 1", bus.in_ready);
        end
        checks++;
        if (bus.sum !== 16'h0000) begin
            errors++;
            $display("FAIL reset_sum got %h expected 0000", bus.sum);
        end
        checks++;
        if ({bus.c_out, bus.ovf} !== 2'b00) begin
            errors++;
            $display("FAIL reset_flags got c_out=%b ovf=%b expected 0 0", bus.c_out, bus.ovf);
        end
    endtask

    task automatic test_single_add();
        int   lat = -1;
        res_t o;
        bus.in_valid  = 1'b1;
        bus.a         = 16'h1234;
        bus.b         = 16'h4321;
        bus.c_in      = 1'b0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL add_accept in_ready got %b expected 1", bus.in_ready);
        end
        next_cycle();
        bus.in_valid = 1'b0;
        for (int n = 1; n <= 10 && lat < 0; n++) begin
            #1;
            if (bus.out_valid === 1'b1) begin
                lat = n;
                o   = {bus.sum, bus.c_out, bus.ovf};
                checks++;
                if (o !== {16'h5555, 1'b0, 1'b0}) begin
                    errors++;
                    $display("FAIL add_result got sum=%h c_out=%b ovf=%b expected sum=5555 c_out=0 ovf=0",
                             o.sum, o.c_out, o.ovf);
                end
            end
            next_cycle();
        end
        checks++;
        if (lat != STAGES) begin
            errors++;
            $display("FAIL add_latency got %0d cycles expected %0d", lat, STAGES);
        end
    endtask

    task automatic test_carry_chain();
        logic [WIDTH-1:0] ta[2] = '{16'hFFFF, 16'h7FFF};
        logic [WIDTH-1:0] tb[2] = '{16'h0000, 16'h0001};
        logic             tc[2] = '{1'b1, 1'b0};
        res_t             te[2] = '{{16'h0000, 1'b1, 1'b0}, {16'h8000, 1'b0, 1'b1}};
        int               sent = 0, got = 0, cyc = 0;
        res_t             e, o;
        while ((sent < 2 || got < 2) && cyc < 40) begin
            bus.out_ready = 1'b1;
            bus.in_valid  = (sent < 2);
            if (sent < 2) begin
                bus.a = ta[sent]; bus.b = tb[sent]; bus.c_in = tc[sent]; bus.sub = 1'b0;
            end
            #1;
            if (bus.out_valid === 1'b1 && bus.out_ready) begin
                o = {bus.sum, bus.c_out, bus.ovf};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL carry_extra got sum=%h with nothing expected", o.sum);
                end else begin
                    e = exp_q.pop_front();
                    if (o !== e) begin
                        errors++;
                        $display("FAIL carry_result got sum=%h c_out=%b ovf=%b expected sum=%h c_out=%b ovf=%b",
                                 o.sum, o.c_out, o.ovf, e.sum, e.c_out, e.ovf);
                    end
                end
                got++;
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(te[sent]);
                sent++;
            end
            next_cycle();
            cyc++;
        end
        bus.in_valid = 1'b0;
        checks++;
        if (got != 2) begin
            errors++;
            $display("FAIL carry_count got %0d results expected 2", got);
        end
    endtask

    task automatic test_subtract();
        logic [WIDTH-1:0] ta[2] = '{16'h0005, 16'h8000};
        logic [WIDTH-1:0] tb[2] = '{16'h0007, 16'h0001};
        logic             tc[2] = '{1'b0, 1'b1};
        res_t             te[2] = '{{16'hFFFE, 1'b0, 1'b0}, {16'h7FFE, 1'b1, 1'b1}};
        int               sent = 0, got = 0, cyc = 0;
        res_t             e, o;
        while ((sent < 2 || got < 2) && cyc < 40) begin
            bus.out_ready = 1'b1;
            bus.in_valid  = (sent < 2);
            if (sent < 2) begin
                bus.a = ta[sent]; bus.b = tb[sent]; bus.c_in = tc[sent]; bus.sub = 1'b1;
            end
            #1;
            if (bus.out_valid === 1'b1 && bus.out_ready) begin
                o = {bus.sum, bus.c_out, bus.ovf};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sub_extra got sum=%h with nothing expected", o.sum);
                end else begin
                    e = exp_q.pop_front();
                    if (o !== e) begin
                        errors++;
                        $display("FAIL sub_result got sum=%h c_out=%b ovf=%b expected sum=%h c_out=%b ovf=%b",
                                 o.sum, o.c_out, o.ovf, e.sum, e.c_out, e.ovf);
                    end
                end
                got++;
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(te[sent]);
                sent++;
            end
            next_cycle();
            cyc++;
        end
        bus.in_valid = 1'b0;
        checks++;
        if (got != 2) begin
            errors++;
            $display("FAIL sub_count got %0d results expected 2", got);
        end
    endtask

    task automatic test_back_to_back();
        int   sent = 0, got = 0, cyc = 0, first = -1, last = -1;
        res_t e, o;
        while ((sent < 10 || got < 10) && cyc < 60) begin
            bus.out_ready = 1'b1;
            bus.in_valid  = (sent < 10);
            if (sent < 10) begin
                bus.a    = WIDTH'($urandom);
                bus.b    = WIDTH'($urandom);
                bus.c_in = 1'($urandom_range(0, 1));
                bus.sub  = 1'($urandom_range(0, 1));
            end
            #1;
            if (bus.out_valid === 1'b1 && bus.out_ready) begin
                o = {bus.sum, bus.c_out, bus.ovf};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_extra got sum=%h with nothing expected", o.sum);
                end else begin
                    e = exp_q.pop_front();
                    if (o !== e) begin
                        errors++;
                        $display("FAIL b2b_result got sum=%h c_out=%b ovf=%b expected sum=%h c_out=%b ovf=%b",
                                 o.sum, o.c_out, o.ovf, e.sum, e.c_out, e.ovf);
                    end
                end
                if (first < 0) first = cyc;
                last = cyc;
                got++;
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model(bus.a, bus.b, bus.c_in, bus.sub));
                sent++;
            end
            next_cycle();
            cyc++;
        end
        bus.in_valid = 1'b0;
        checks++;
        if (got != 10 || (last - first) != 9) begin
            errors++;
            $display("FAIL b2b_stream got %0d results over %0d cycles expected 10 over 10",
                     got, last - first + 1);
        end
    endtask

    task automatic test_backpressure();
        int   sent = 0, got = 0, cyc = 0, stalls = 0;
        logic pending = 1'b0;
        logic held_ok = 1'b0;
        res_t e, o, held;
        while ((sent < 6 || got < 6) && cyc < 60) begin
            bus.out_ready = !(cyc >= 5 && cyc <= 7);
            if (!pending && sent < 6) begin
                bus.a    = WIDTH'($urandom);
                bus.b    = WIDTH'($urandom);
                bus.c_in = 1'($urandom_range(0, 1));
                bus.sub  = 1'($urandom_range(0, 1));
                pending  = 1'b1;
            end
            bus.in_valid = pending;
            #1;
            o = {bus.sum, bus.c_out, bus.ovf};
            if (bus.out_valid === 1'b1 && !bus.out_ready) begin
                stalls++;
                checks++;
                if (bus.in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_in_ready got %b expected 0 at cycle %0d", bus.in_ready, cyc);
                end
                if (held_ok) begin
                    checks++;
                    if (o !== held) begin
                        errors++;
                        $display("FAIL bp_hold got sum=%h c_out=%b ovf=%b expected sum=%h c_out=%b ovf=%b",
                                 o.sum, o.c_out, o.ovf, held.sum, held.c_out, held.ovf);
                    end
                end
                held    = o;
                held_ok = 1'b1;
            end else begin
                held_ok = 1'b0;
            end
            if (bus.out_valid === 1'b1 && bus.out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL bp_extra got sum=%h with nothing expected", o.sum);
                end else begin
                    e = exp_q.pop_front();
                    if (o !== e) begin
                        errors++;
                        $display("FAIL bp_result got sum=%h c_out=%b ovf=%b expected sum=%h c_out=%b ovf=%b",
                                 o.sum, o.c_out, o.ovf, e.sum, e.c_out, e.ovf);
                    end
                end
                got++;
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model(bus.a, bus.b, bus.c_in, bus.sub));
                sent++;
                pending = 1'b0;
            end
            next_cycle();
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        checks++;
        if (got != 6 || stalls != 3 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL bp_count got results=%0d stalls=%0d leftover=%0d expected 6 3 0",
                     got, stalls, exp_q.size());
        end
    endtask

    task automatic test_reset_midflight();
        int   stray = 0, lat = -1;
        res_t e, o;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.a        = WIDTH'($urandom);
            bus.b        = WIDTH'($urandom);
            bus.c_in     = 1'b0;
            bus.sub      = 1'b0;
            next_cycle();
        end
        rst          = 1'b1;
        bus.a        = 16'hABCD;
        next_cycle();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_after_reset got out_valid=%b expected 0", bus.out_valid);
        end
        for (int i = 0; i < 8; i++) begin
            if (bus.out_valid !== 1'b0) stray++;
            next_cycle();
            #1;
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL rstmid_stale got %0d valid cycles expected 0", stray);
        end
        bus.in_valid = 1'b1;
        bus.a        = 16'h0F0F;
        bus.b        = 16'h00F1;
        bus.c_in     = 1'b1;
        bus.sub      = 1'b1;
        e            = model(bus.a, bus.b, bus.c_in, bus.sub);
        next_cycle();
        bus.in_valid = 1'b0;
        for (int n = 1; n <= 10 && lat < 0; n++) begin
            #1;
            if (bus.out_valid === 1'b1) begin
                lat = n;
                o   = {bus.sum, bus.c_out, bus.ovf};
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL rstmid_result got sum=%h c_out=%b ovf=%b expected sum=%h c_out=%b ovf=%b",
                             o.sum, o.c_out, o.ovf, e.sum, e.c_out, e.ovf);
                end
            end
            next_cycle();
        end
        checks++;
        if (lat != STAGES) begin
            errors++;
            $display("FAIL rstmid_latency got %0d cycles expected %0d", lat, STAGES);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_add();
        test_carry_chain();
        test_subtract();
        test_back_to_back();
        test_backpressure();
        exp_q.delete();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
